// File: rtl/icache_pkg.sv
// ----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the icache tag controller: address field widths,
// controller state encoding and helpers to split a fetch address into its
// tag / set index and to rebuild a line-aligned address.
// ----------------------------------------------------------------------------
package icache_pkg;

    localparam int ADDR_W = 32;
    localparam int OFF_W  = 5;
    localparam int IDX_W  = 4;
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int N_SETS = 1 << IDX_W;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        MISS_REQ  = 3'd2,
        MISS_WAIT = 3'd3,
        FILL      = 3'd4
    } state_e;

    function automatic logic [IDX_W-1:0] get_idx(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: IDX_W];
    endfunction

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [IDX_W-1:0] idx);
        return {tag, idx, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_valid_array.sv
// ----------------------------------------------------------------------------
// icache_valid_array
// One valid flop per icache set.  A set request marks one entry valid, a
// clear_all request invalidates every entry; clear_all wins when both are
// requested in the same cycle.  Read is combinational by set index.
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous active-high reset (all entries invalid)
//   set_i        mark entry set_idx_i valid at the next edge
//   set_idx_i    entry to mark valid
//   clear_all_i  invalidate all entries at the next edge
//   rd_idx_i     entry to read
//   rd_valid_o   valid bit of entry rd_idx_i
// ----------------------------------------------------------------------------
module icache_valid_array
    import icache_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             set_i,
    input  logic [IDX_W-1:0] set_idx_i,
    input  logic             clear_all_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o
);

    logic [N_SETS-1:0] valid_q;
    logic [N_SETS-1:0] valid_d;

    always_comb begin
        valid_d = valid_q;
        if (clear_all_i) begin
            valid_d = '0;
        end else if (set_i) begin
            valid_d[set_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/icache_tag_ctrl.sv
// ----------------------------------------------------------------------------
// icache_tag_ctrl
// Sequences the 16-set direct-mapped icache tag SRAM (1W/1R).  Accepts fetch
// lookups, reads the tag SRAM, compares against the stored tag and the valid
// array, and reports hit/miss.  A miss issues a line request, waits for the
// fill to complete, writes the new tag and marks the set valid.
//
// Ports
//   clk_i / rst_i             clock, asynchronous active-high reset
//   req_valid_i/req_addr_i    lookup request
//   req_ready_o               lookup accepted when req_valid_i && req_ready_o
//   resp_valid_o/resp_hit_o   one-cycle completion pulse, 1=hit 0=serviced miss
//   miss_valid_o/miss_addr_o  line fill request (line aligned), miss_ready_i
//   fill_done_i               line data written, tag may be committed
//   flush_i                   invalidate all sets
//   tag_csb0_o/addr0/din0     tag SRAM write port (chip select active low)
//   tag_csb1_o/addr1/dout1    tag SRAM read port, data valid one cycle later
//
// state     | meaning
// IDLE      | no lookup in flight, ready for a request
// COMPARE   | SRAM tag available, compare and answer hit or go to miss
// MISS_REQ  | line request presented, waiting for miss_ready_i
// MISS_WAIT | waiting for fill_done_i
// FILL      | write tag, set valid, report serviced miss (one cycle)
// ----------------------------------------------------------------------------
module icache_tag_ctrl
    import icache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              req_ready_o,
    output logic              resp_valid_o,
    output logic              resp_hit_o,
    output logic              miss_valid_o,
    output logic [ADDR_W-1:0] miss_addr_o,
    input  logic              miss_ready_i,
    input  logic              fill_done_i,
    input  logic              flush_i,
    output logic              tag_csb0_o,
    output logic [IDX_W-1:0]  tag_addr0_o,
    output logic [TAG_W-1:0]  tag_din0_o,
    output logic              tag_csb1_o,
    output logic [IDX_W-1:0]  tag_addr1_o,
    input  logic [TAG_W-1:0]  tag_dout1_i
);

    state_e           state_q;
    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] idx_q;
    logic             drop_q;
    logic             fwd_v_q;
    logic [IDX_W-1:0] fwd_idx_q;
    logic [TAG_W-1:0] fwd_tag_q;

    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;
    logic             cmp_hit;
    logic             accept;
    logic             in_fill;
    logic             unused_offset;

    // Byte offset within the line plays no part in tag lookup.
    assign unused_offset = ^req_addr_i[OFF_W-1:0];

    assign in_fill = (state_q == FILL);

    // The SRAM write in FILL lands on the same edge as a read issued in FILL,
    // so that read returns the old tag; the forwarded copy covers that case.
    always_comb begin
        rd_tag = tag_dout1_i;
        if (fwd_v_q && (fwd_idx_q == idx_q)) begin
            rd_tag = fwd_tag_q;
        end
    end

    assign cmp_hit     = (state_q == COMPARE) && rd_valid && (rd_tag == tag_q);
    assign req_ready_o = !rst_i && ((state_q == IDLE) || cmp_hit || in_fill);
    assign accept      = req_valid_i && req_ready_o;

    icache_valid_array u_valid_array (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .set_i       (in_fill && !drop_q),
        .set_idx_i   (idx_q),
        .clear_all_i (flush_i),
        .rd_idx_i    (idx_q),
        .rd_valid_o  (rd_valid)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            tag_q     <= '0;
            idx_q     <= '0;
            drop_q    <= 1'b0;
            fwd_v_q   <= 1'b0;
            fwd_idx_q <= '0;
            fwd_tag_q <= '0;
        end else begin
            fwd_v_q <= 1'b0;
            if (accept) begin
                tag_q <= get_tag(req_addr_i);
                idx_q <= get_idx(req_addr_i);
            end
            // A flush while a fill is outstanding must not let that fill
            // revalidate its set.
            if (flush_i && ((state_q == MISS_REQ) || (state_q == MISS_WAIT))) begin
                drop_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (cmp_hit) begin
                        state_q <= accept ? COMPARE : IDLE;
                    end else begin
                        state_q <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (miss_ready_i) begin
                        state_q <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (fill_done_i) begin
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    drop_q    <= 1'b0;
                    fwd_v_q   <= 1'b1;
                    fwd_idx_q <= idx_q;
                    fwd_tag_q <= tag_q;
                    state_q   <= accept ? COMPARE : IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid_o = cmp_hit || in_fill;
    assign resp_hit_o   = cmp_hit;

    assign miss_valid_o = (state_q == MISS_REQ);
    assign miss_addr_o  = miss_valid_o ? line_addr(tag_q, idx_q) : '0;

    assign tag_csb0_o  = !in_fill;
    assign tag_addr0_o = in_fill ? idx_q : '0;
    assign tag_din0_o  = in_fill ? tag_q : '0;

    assign tag_csb1_o  = !accept;
    assign tag_addr1_o = accept ? get_idx(req_addr_i) : '0;

endmodule

// File: tb/tb_icache_tag_ctrl.sv
module tb_icache_tag_ctrl;
    import icache_pkg::*;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_hit;
    logic              miss_valid;
    logic [ADDR_W-1:0] miss_addr;
    logic              miss_ready;
    logic              fill_done;
    logic              flush;
    logic              tag_csb0;
    logic [IDX_W-1:0]  tag_addr0;
    logic [TAG_W-1:0]  tag_din0;
    logic              tag_csb1;
    logic [IDX_W-1:0]  tag_addr1;
    logic [TAG_W-1:0]  tag_dout1;

    int n_vec = 0;
    int n_err = 0;

    icache_tag_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_addr_i   (req_addr),
        .req_ready_o  (req_ready),
        .resp_valid_o (resp_valid),
        .resp_hit_o   (resp_hit),
        .miss_valid_o (miss_valid),
        .miss_addr_o  (miss_addr),
        .miss_ready_i (miss_ready),
        .fill_done_i  (fill_done),
        .flush_i      (flush),
        .tag_csb0_o   (tag_csb0),
        .tag_addr0_o  (tag_addr0),
        .tag_din0_o   (tag_din0),
        .tag_csb1_o   (tag_csb1),
        .tag_addr1_o  (tag_addr1),
        .tag_dout1_i  (tag_dout1)
    );

    // Tag SRAM: write and read both commit at the clock edge, read returns old data.
    logic [TAG_W-1:0] mem [N_SETS];
    always @(posedge clk) begin
        if (!tag_csb0) mem[tag_addr0] <= tag_din0;
        if (!tag_csb1) tag_dout1 <= mem[tag_addr1];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // From IDLE/FILL: present a request, confirm it is accepted, move to COMPARE.
    task automatic start_req(input string nm, input logic [31:0] a, input logic [3:0] idx);
        req_valid = 1'b1;
        req_addr  = a;
        settle();
        chk({nm, "_ready"}, 32'(req_ready), 32'd1);
        chk({nm, "_csb1"}, 32'(tag_csb1), 32'd0);
        chk({nm, "_addr1"}, 32'(tag_addr1), 32'(idx));
        cyc();
        req_valid = 1'b0;
    endtask

    // From COMPARE of a missing line: miss request, fill, stop in FILL.
    task automatic miss_fill(input string nm, input logic [31:0] line,
                             input logic [22:0] tag, input logic [3:0] idx);
        settle();
        chk({nm, "_cmp_resp"}, 32'(resp_valid), 32'd0);
        cyc();
        settle();
        chk({nm, "_miss_valid"}, 32'(miss_valid), 32'd1);
        chk({nm, "_miss_addr"}, miss_addr, line);
        miss_ready = 1'b1;
        cyc();
        miss_ready = 1'b0;
        fill_done  = 1'b1;
        cyc();
        fill_done  = 1'b0;
        settle();
        chk({nm, "_fill_resp"}, 32'(resp_valid), 32'd1);
        chk({nm, "_fill_hit"}, 32'(resp_hit), 32'd0);
        chk({nm, "_csb0"}, 32'(tag_csb0), 32'd0);
        chk({nm, "_addr0"}, 32'(tag_addr0), 32'(idx));
        chk({nm, "_din0"}, 32'(tag_din0), 32'(tag));
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        miss_ready = 1'b0;
        fill_done  = 1'b0;
        flush      = 1'b0;
        cyc();
        cyc();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_miss", 32'(miss_valid), 32'd0);
        chk("rst_csb0", 32'(tag_csb0), 32'd1);
        chk("rst_csb1", 32'(tag_csb1), 32'd1);
        chk("rst_valid", 32'(dut.u_valid_array.valid_q), 32'h0);
        rst = 1'b0;
        cyc();

        // Cold miss on 0x1040 (set 2, tag 8)
        start_req("cold_req", 32'h0000_1040, 4'd2);
        miss_fill("cold", 32'h0000_1040, 23'h8, 4'd2);
        cyc();
        chk("cold_valid", 32'(dut.u_valid_array.valid_q), 32'h0004);

        // Back-to-back hits, one per cycle
        req_valid = 1'b1;
        req_addr  = 32'h0000_1040;
        cyc();
        req_addr  = 32'h0000_1044;
        settle();
        chk("hit1_resp", 32'(resp_valid), 32'd1);
        chk("hit1_hit", 32'(resp_hit), 32'd1);
        chk("hit1_ready", 32'(req_ready), 32'd1);
        cyc();
        req_addr  = 32'h0000_105C;
        settle();
        chk("hit2_resp", 32'(resp_valid), 32'd1);
        chk("hit2_hit", 32'(resp_hit), 32'd1);
        cyc();
        req_valid = 1'b0;
        settle();
        chk("hit3_resp", 32'(resp_valid), 32'd1);
        chk("hit3_hit", 32'(resp_hit), 32'd1);
        cyc();
        settle();
        chk("hits_idle_resp", 32'(resp_valid), 32'd0);

        // Conflict in set 2: 0x3040 replaces 0x1040, then 0x1040 misses
        start_req("conf_req", 32'h0000_3040, 4'd2);
        miss_fill("conf", 32'h0000_3040, 23'h18, 4'd2);
        cyc();
        start_req("conf_back_req", 32'h0000_1040, 4'd2);
        miss_fill("conf_back", 32'h0000_1040, 23'h8, 4'd2);
        req_valid = 1'b1;
        req_addr  = 32'h0000_2040;
        settle();
        chk("conf_fill_ready", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 1'b0;
        miss_fill("set2_new", 32'h0000_2040, 23'h10, 4'd2);
        cyc();

        // Forward hazard: SRAM holds tag 0x10; request 0x2040 during fill of 0x1040
        start_req("haz_a_req", 32'h0000_1040, 4'd2);
        miss_fill("haz_a", 32'h0000_1040, 23'h8, 4'd2);
        req_valid = 1'b1;
        req_addr  = 32'h0000_2040;
        cyc();
        req_valid = 1'b0;
        miss_fill("haz", 32'h0000_2040, 23'h10, 4'd2);
        // Same line requested during its own fill: forwarded tag gives a hit
        req_valid = 1'b1;
        req_addr  = 32'h0000_2044;
        cyc();
        req_valid = 1'b0;
        settle();
        chk("fwd_hit_resp", 32'(resp_valid), 32'd1);
        chk("fwd_hit_hit", 32'(resp_hit), 32'd1);
        cyc();

        // Flush during MISS_WAIT for 0x0080 (set 4, tag 0)
        start_req("fl_req", 32'h0000_0080, 4'd4);
        settle();
        chk("fl_cmp_resp", 32'(resp_valid), 32'd0);
        cyc();
        settle();
        chk("fl_miss_addr", miss_addr, 32'h0000_0080);
        miss_ready = 1'b1;
        cyc();
        miss_ready = 1'b0;
        flush      = 1'b1;
        cyc();
        flush      = 1'b0;
        settle();
        chk("fl_cleared", 32'(dut.u_valid_array.valid_q), 32'h0);
        fill_done  = 1'b1;
        cyc();
        fill_done  = 1'b0;
        settle();
        chk("fl_fill_resp", 32'(resp_valid), 32'd1);
        chk("fl_fill_hit", 32'(resp_hit), 32'd0);
        chk("fl_fill_csb0", 32'(tag_csb0), 32'd0);
        cyc();
        chk("fl_drop_valid", 32'(dut.u_valid_array.valid_q), 32'h0);
        start_req("refl_req", 32'h0000_0080, 4'd4);
        miss_fill("refl", 32'h0000_0080, 23'h0, 4'd4);
        cyc();
        chk("refl_valid", 32'(dut.u_valid_array.valid_q), 32'h0010);

        // Backpressure on the miss request, then reset mid-miss
        start_req("bp_req", 32'h0000_1040, 4'd2);
        settle();
        chk("bp_cmp_resp", 32'(resp_valid), 32'd0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_miss_valid", 32'(miss_valid), 32'd1);
            chk("bp_miss_addr", miss_addr, 32'h0000_1040);
            cyc();
        end
        rst = 1'b1;
        settle();
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_miss", 32'(miss_valid), 32'd0);
        chk("mid_rst_valid", 32'(dut.u_valid_array.valid_q), 32'h0);
        chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        cyc();
        rst = 1'b0;
        settle();
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        start_req("post_rst_req", 32'h0000_1040, 4'd2);
        settle();
        chk("post_rst_miss", 32'(resp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
